adau1761_cfg_seq: RTL and testbench

Boot-time configuration sequencer for the ADAU1761 codec behind the serial audio path. On a start pulse it walks an external table of register writes. Each 24-bit entry holds a 16-bit register address and 8-bit data, and is issued as a 4-byte I2C write. Table entries with address 16'hFFFF are timed waits, used for PLL lock settling. Software or the top level holds off the serial datapath until `done` with `error`=0.

---
 rtl/adau1761_cfg_seq_if.sv | 26 ++
 rtl/adau1761_cfg_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_adau1761_cfg_seq.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adau1761_cfg_seq_if.sv
// Sequencer-side bundle: start/status handshake, register table lookup and I2C pad controls.
// The master modport is the sequencer; the slave modport is the table/pad side.
interface adau1761_cfg_seq_if #(
    parameter int IDX_W = 6
);
    logic             start;
    logic             busy;
    logic             done;
    logic             error;
    logic [IDX_W-1:0] nack_idx;
    logic [IDX_W-1:0] cfg_idx;
    logic [23:0]      cfg_word;
    logic             scl_oe;
    logic             sda_oe;
    logic             sda_i;

    modport master (
        input  start, cfg_word, sda_i,
        output busy, done, error, nack_idx, cfg_idx, scl_oe, sda_oe
    );

    modport slave (
        output start, cfg_word, sda_i,
        input  busy, done, error, nack_idx, cfg_idx, scl_oe, sda_oe
    );
endinterface

// File: rtl/adau1761_cfg_seq.sv
// ADAU1761 boot sequencer: walks a register table, issuing 4-byte I2C writes or timed waits.
// Latency: write entry 1 + 39*4*CLK_DIV cycles, wait entry 1 + data*DELAY_UNIT; done in FIN.
// Backpressure: start is ignored while busy (including FIN); NACK aborts via STOP then FIN.
module adau1761_cfg_seq #(
    parameter int         CLK_DIV    = 125,
    parameter logic [6:0] DEV_ADDR   = 7'h38,
    parameter int         N_REGS     = 64,
    parameter int         DELAY_UNIT = 1024,
    localparam int        IDX_W      = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic               aclk,
    input  logic               aresetn,
    adau1761_cfg_seq_if.master cfg
);

    localparam int          QW        = $clog2(CLK_DIV);
    localparam logic [23:0] DU24      = 24'(DELAY_UNIT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_DELAY, S_START, S_BIT, S_STOP, S_GAP, S_FIN
    } state_t;

    state_t           state_q, state_n;
    logic [QW-1:0]    qcnt_q, qcnt_n;
    logic [1:0]       qidx_q, qidx_n;
    logic [3:0]       bit_q, bit_n;
    logic [1:0]       byte_q, byte_n;
    logic [23:0]      dcnt_q, dcnt_n;
    logic [31:0]      shreg_q, shreg_n;
    logic             abort_q, abort_n;
    logic             error_q, error_n;
    logic [IDX_W-1:0] nack_q, nack_n;
    logic [IDX_W-1:0] idx_q, idx_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             scl_q, scl_n;
    logic             sda_q, sda_n;

    logic             q_end;
    logic             ph_end;
    logic             adv;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            qcnt_q  <= '0;
            qidx_q  <= '0;
            bit_q   <= '0;
            byte_q  <= '0;
            dcnt_q  <= '0;
            shreg_q <= '0;
            abort_q <= 1'b0;
            error_q <= 1'b0;
            nack_q  <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            scl_q   <= 1'b0;
            sda_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            qcnt_q  <= qcnt_n;
            qidx_q  <= qidx_n;
            bit_q   <= bit_n;
            byte_q  <= byte_n;
            dcnt_q  <= dcnt_n;
            shreg_q <= shreg_n;
            abort_q <= abort_n;
            error_q <= error_n;
            nack_q  <= nack_n;
            idx_q   <= idx_n;
            busy_q  <= busy_n;
            done_q  <= done_n;
            scl_q   <= scl_n;
            sda_q   <= sda_n;
        end
    end

    always_comb begin
        state_n = state_q;
        qcnt_n  = qcnt_q;
        qidx_n  = qidx_q;
        bit_n   = bit_q;
        byte_n  = byte_q;
        dcnt_n  = dcnt_q;
        shreg_n = shreg_q;
        abort_n = abort_q;
        error_n = error_q;
        nack_n  = nack_q;
        idx_n   = idx_q;
        adv     = 1'b0;
        scl_n   = 1'b0;
        sda_n   = 1'b0;

        q_end  = (qcnt_q == QW'(CLK_DIV - 1));
        ph_end = q_end && (qidx_q == 2'd3);

        // Quarter timing is shared by every bus phase; it is simply ignored elsewhere.
        if (state_q == S_START || state_q == S_BIT || state_q == S_STOP || state_q == S_GAP) begin
            if (q_end) begin
                qcnt_n = '0;
                qidx_n = qidx_q + 2'd1;
            end else begin
                qcnt_n = qcnt_q + QW'(1);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (cfg.start) begin
                    state_n = S_LOAD;
                    idx_n   = '0;
                    error_n = 1'b0;
                    abort_n = 1'b0;
                end
            end
            S_LOAD: begin
                qcnt_n = '0;
                qidx_n = '0;
                bit_n  = '0;
                byte_n = '0;
                if (cfg.cfg_word[23:8] == 16'hFFFF) begin
                    if (cfg.cfg_word[7:0] == 8'd0) begin
                        adv = 1'b1;
                    end else begin
                        state_n = S_DELAY;
                        dcnt_n  = {16'd0, cfg.cfg_word[7:0]} * DU24;
                    end
                end else begin
                    shreg_n = {DEV_ADDR, 1'b0, cfg.cfg_word};
                    state_n = S_START;
                end
            end
            S_DELAY: begin
                if (dcnt_q <= 24'd1) begin
                    adv = 1'b1;
                end else begin
                    dcnt_n = dcnt_q - 24'd1;
                end
            end
            S_START: begin
                if (ph_end) begin
                    state_n = S_BIT;
                end
            end
            S_BIT: begin
                // ACK sampled at the end of the first SCL-high quarter, well after the rising edge.
                if (bit_q == 4'd8 && qidx_q == 2'd2 && q_end && cfg.sda_i) begin
                    error_n = 1'b1;
                    nack_n  = idx_q;
                    abort_n = 1'b1;
                end
                if (ph_end) begin
                    if (bit_q == 4'd8) begin
                        bit_n = '0;
                        if (abort_q || byte_q == 2'd3) begin
                            state_n = S_STOP;
                        end else begin
                            byte_n = byte_q + 2'd1;
                        end
                    end else begin
                        bit_n   = bit_q + 4'd1;
                        shreg_n = {shreg_q[30:0], 1'b0};
                    end
                end
            end
            S_STOP: begin
                if (ph_end) begin
                    state_n = S_GAP;
                end
            end
            S_GAP: begin
                if (ph_end) begin
                    if (abort_q) begin
                        state_n = S_FIN;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            S_FIN: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        if (adv) begin
            if (idx_q == LAST_IDX) begin
                state_n = S_FIN;
            end else begin
                idx_n   = idx_q + IDX_W'(1);
                state_n = S_LOAD;
            end
        end

        // Pad controls are decoded from next-state values so they are registered yet aligned.
        case (state_n)
            S_START: begin
                scl_n = (qidx_n == 2'd3);
                sda_n = (qidx_n >= 2'd2);
            end
            S_BIT: begin
                scl_n = (qidx_n < 2'd2);
                sda_n = (bit_n != 4'd8) && !shreg_n[31];
            end
            S_STOP: begin
                scl_n = (qidx_n == 2'd0);
                sda_n = (qidx_n < 2'd2);
            end
            default: begin
                scl_n = 1'b0;
                sda_n = 1'b0;
            end
        endcase

        busy_n = (state_n != S_IDLE);
        done_n = (state_n == S_FIN);
    end

    assign cfg.busy     = busy_q;
    assign cfg.done     = done_q;
    assign cfg.error    = error_q;
    assign cfg.nack_idx = nack_q;
    assign cfg.cfg_idx  = idx_q;
    assign cfg.scl_oe   = scl_q;
    assign cfg.sda_oe   = sda_q;

endmodule

// File: tb/tb_adau1761_cfg_seq.sv
// Bench for adau1761_cfg_seq: I2C slave/decoder on the pad controls plus a table-level timing model.
module tb_adau1761_cfg_seq;

    localparam int CD = 4;
    localparam int NR = 4;
    localparam int DU = 16;
    localparam int IW = 2;

    logic aclk    = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    adau1761_cfg_seq_if #(.IDX_W(IW)) bus ();

    adau1761_cfg_seq #(
        .CLK_DIV   (CD),
        .DEV_ADDR  (7'h38),
        .N_REGS    (NR),
        .DELAY_UNIT(DU)
    ) dut (
        .aclk   (aclk),
        .aresetn(aresetn),
        .cfg    (bus)
    );

    logic [23:0] tbl [NR];
    logic        pull = 1'b0;

    assign bus.cfg_word = tbl[bus.cfg_idx];
    assign bus.sda_i    = ~(bus.sda_oe | pull);

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    int cyc = 0;
    always @(posedge aclk) cyc <= cyc + 1;

    // Monitor / slave state
    int          done_cnt, done_cyc, busy_cyc;
    logic        err_at_rise;
    logic        prev_busy, prev_scl, prev_sda, in_frame;
    logic [IW-1:0] idx_seq[$];
    logic [7:0]  obs_bytes[$];
    int          obs_frame_cyc[$];
    int          bitpos, byte_no, frame_no, run_len, proto_err;
    int          nack_frame = -1;
    int          nack_byte  = -1;
    logic [7:0]  sh;

    always @(negedge aclk) begin
        if (!aresetn) begin
            pull      = 1'b0;
            in_frame  = 1'b0;
            bitpos    = 0;
            byte_no   = 0;
            run_len   = 0;
            prev_scl  = bus.scl_oe;
            prev_sda  = bus.sda_oe;
            prev_busy = bus.busy;
        end else begin
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (bus.busy && !prev_busy) begin
                busy_cyc    = cyc;
                err_at_rise = bus.error;
            end
            prev_busy = bus.busy;
            if (bus.busy && (idx_seq.size() == 0 || idx_seq[$] != bus.cfg_idx))
                idx_seq.push_back(bus.cfg_idx);

            // SDA moving while SCL stays released is only legal as START or STOP.
            if (!prev_scl && !bus.scl_oe && prev_sda != bus.sda_oe) begin
                if (bus.sda_oe) begin
                    if (in_frame) proto_err++;
                    in_frame = 1'b1;
                    bitpos   = 0;
                    byte_no  = 0;
                    obs_frame_cyc.push_back(cyc);
                end else begin
                    if (!in_frame) proto_err++;
                    in_frame = 1'b0;
                    frame_no++;
                end
            end
            if (prev_scl && !bus.scl_oe && in_frame) begin
                if (bitpos >= 1 && bitpos <= 8 && run_len != 2 * CD) proto_err++;
                if (bitpos < 8) begin
                    sh = {sh[6:0], ~bus.sda_oe};
                    if (bitpos == 7) obs_bytes.push_back(sh);
                end
                bitpos++;
            end
            if (!prev_scl && bus.scl_oe && in_frame) begin
                if (bitpos >= 1 && bitpos <= 9 && run_len != 2 * CD) proto_err++;
                if (bitpos == 8) begin
                    pull = !(frame_no == nack_frame && byte_no == nack_byte);
                end else if (bitpos == 9) begin
                    pull    = 1'b0;
                    bitpos  = 0;
                    byte_no++;
                end
            end
            run_len  = (prev_scl == bus.scl_oe) ? run_len + 1 : 1;
            prev_scl = bus.scl_oe;
            prev_sda = bus.sda_oe;
        end
    end

    task automatic clear_logs();
        done_cnt    = 0;
        done_cyc    = -1;
        busy_cyc    = -1;
        err_at_rise = 1'b1;
        frame_no    = 0;
        proto_err   = 0;
        idx_seq.delete();
        obs_bytes.delete();
        obs_frame_cyc.delete();
    endtask

    // Runs one sequence over tbl; nack_ent<0 means every byte is ACKed.
    task automatic run_seq(input int nack_ent, input int nack_b, input bit inject, input string nm);
        int          t, nb, wr, ts, enidx;
        bit          eerr;
        logic [31:0] fw;
        logic [7:0]  eb[$];
        int          ef[$];
        int          eidx[$];

        t = 1; wr = 0; eerr = 1'b0; enidx = 0;
        nack_frame = -1;
        nack_byte  = -1;
        for (int i = 0; i < NR; i++) begin
            eidx.push_back(i);
            if (tbl[i][23:8] == 16'hFFFF) begin
                t += 1 + int'(tbl[i][7:0]) * DU;
            end else begin
                ef.push_back(t + 1 + 2 * CD);
                fw = {8'h70, tbl[i]};
                nb = (i == nack_ent) ? nack_b + 1 : 4;
                for (int b = 0; b < nb; b++) eb.push_back(fw[31 - 8 * b -: 8]);
                if (i == nack_ent) begin
                    nack_frame = wr;
                    nack_byte  = nack_b;
                    t += 1 + (3 + 9 * nb) * 4 * CD;
                    eerr  = 1'b1;
                    enidx = i;
                    break;
                end
                t += 1 + 39 * 4 * CD;
                wr++;
            end
        end

        clear_logs();
        @(negedge aclk);
        ts = cyc;
        bus.start = 1'b1;
        for (int k = 1; k <= t + 30; k++) begin
            @(negedge aclk);
            bus.start = inject && (cyc == ts + t / 2 || cyc == ts + t);
        end
        bus.start = 1'b0;

        chk({nm, ".done_cnt"}, done_cnt, 1);
        chk({nm, ".done_cyc"}, done_cyc - ts, t);
        chk({nm, ".busy_rise"}, busy_cyc - ts, 1);
        chk({nm, ".busy_end"}, bus.busy, 0);
        chk({nm, ".err_cleared"}, err_at_rise, 0);
        chk({nm, ".error"}, bus.error, eerr);
        if (eerr) chk({nm, ".nack_idx"}, bus.nack_idx, enidx);
        chk({nm, ".idx_cnt"}, idx_seq.size(), eidx.size());
        for (int i = 0; i < idx_seq.size() && i < eidx.size(); i++)
            chk($sformatf("%s.idx%0d", nm, i), idx_seq[i], eidx[i]);
        chk({nm, ".byte_cnt"}, obs_bytes.size(), eb.size());
        for (int i = 0; i < obs_bytes.size() && i < eb.size(); i++)
            chk($sformatf("%s.byte%0d", nm, i), obs_bytes[i], eb[i]);
        chk({nm, ".frame_cnt"}, obs_frame_cyc.size(), ef.size());
        for (int i = 0; i < obs_frame_cyc.size() && i < ef.size(); i++)
            chk($sformatf("%s.frame%0d_t", nm, i), obs_frame_cyc[i] - ts, ef[i]);
        chk({nm, ".stops"}, frame_no, ef.size());
        chk({nm, ".protocol"}, proto_err, 0);
    endtask

    initial begin
        int ne, nbt;
        int w[$];

        bus.start = 1'b0;
        tbl = '{24'h400001, 24'h400001, 24'h400001, 24'h400001};
        repeat (3) @(negedge aclk);
        aresetn = 1'b1;
        @(negedge aclk);
        chk("rst.busy", bus.busy, 0);
        chk("rst.done", bus.done, 0);
        chk("rst.error", bus.error, 0);
        chk("rst.nack_idx", bus.nack_idx, 0);
        chk("rst.cfg_idx", bus.cfg_idx, 0);
        chk("rst.pads", {bus.scl_oe, bus.sda_oe}, 0);

        tbl = '{24'h400001, 24'hFFFF02, 24'h401501, 24'h4016AA};
        run_seq(-1, 0, 1'b0, "three");

        tbl = '{24'h400001, 24'h401203, 24'h402004, 24'h4030AB};
        run_seq(1, 1, 1'b0, "nack");

        tbl = '{24'h4000C5, 24'hFFFF00, 24'h40F13C, 24'hFFFF01};
        run_seq(-1, 0, 1'b1, "inject");

        // Asynchronous reset in the middle of byte 2 of the first frame.
        tbl = '{24'h40A55A, 24'h400102, 24'h400203, 24'h400304};
        clear_logs();
        nack_frame = -1;
        @(negedge aclk);
        bus.start = 1'b1;
        @(negedge aclk);
        bus.start = 1'b0;
        repeat (4 * CD + 72 * CD + 10) @(negedge aclk);
        chk("rstmid.busy_before", bus.busy, 1);
        #2 aresetn = 1'b0;
        #1;
        chk("rstmid.pads", {bus.scl_oe, bus.sda_oe}, 0);
        chk("rstmid.outs", {bus.busy, bus.done, bus.error, 2'(bus.nack_idx), 2'(bus.cfg_idx)}, 0);
        repeat (3) @(negedge aclk);
        #2 aresetn = 1'b1;
        run_seq(-1, 0, 1'b0, "post_rst");

        for (int r = 0; r < 6; r++) begin
            w.delete();
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tbl[i] = {16'hFFFF, 8'($urandom_range(0, 5))};
                end else begin
                    tbl[i] = {16'($urandom_range(0, 16'hFFFE)), 8'($urandom_range(0, 255))};
                    w.push_back(i);
                end
            end
            ne  = -1;
            nbt = 0;
            if (w.size() > 0 && $urandom_range(0, 2) == 0) begin
                ne  = w[$urandom_range(0, w.size() - 1)];
                nbt = $urandom_range(0, 3);
            end
            run_seq(ne, nbt, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
